// File: rtl/hyper_burst_splitter.sv
// hyper_burst_splitter: splits one HyperBus transaction descriptor into PHY
// bursts bounded by the chip-select max length (tCSM), issues them one at a
// time, and pulses a completion strobe after the last burst finishes.
// Optional feature: define HYPER_BURST_PAGE_SPLIT_EN to also stop bursts at
// 2^PAGE_BYTES_LOG2-byte page boundaries.
module hyper_burst_splitter #(
  parameter int TRANS_SIZE      = 16,
  parameter int TRANS_DATA_SIZE = 32 + TRANS_SIZE + 4 + 1,
  parameter int PAGE_BYTES_LOG2 = 10
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [TRANS_DATA_SIZE-1:0] trans_data_i,
  input  logic                       trans_valid_i,
  output logic                       trans_ready_o,
  input  logic [15:0]                cfg_cs_max_i,
  output logic [31:0]                burst_addr_o,
  output logic [TRANS_SIZE-1:0]      burst_len_o,
  output logic                       burst_rx_o,
  output logic                       burst_reg_o,
  output logic                       burst_last_o,
  output logic                       burst_valid_o,
  input  logic                       burst_ready_i,
  input  logic                       phy_done_i,
  output logic                       trans_done_o,
  output logic                       busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                r_state;
  logic [31:0]           r_cur_addr;
  logic [TRANS_SIZE-1:0] r_remaining;
  logic [15:0]           r_cs_lim;
  logic                  r_rx;
  logic                  r_reg;

  logic [31:0]           w_addr;
  logic [TRANS_SIZE-1:0] w_size;
  logic                  w_rx;
  logic [3:0]            w_mode;
  logic [31:0]           w_len32;
  logic [TRANS_SIZE-1:0] w_len;
  logic                  w_unused;

  assign w_addr = trans_data_i[TRANS_DATA_SIZE-1 -: 32];
  assign w_size = trans_data_i[TRANS_SIZE+4:5];
  assign w_rx   = trans_data_i[4];
  assign w_mode = trans_data_i[3:0];

  // mode[3], cs_max[0] and the upper length bits carry no information here
  assign w_unused = ^{w_mode[3], cfg_cs_max_i[0], w_len32[31:TRANS_SIZE]};

`ifdef HYPER_BURST_PAGE_SPLIT_EN
  logic [31:0] w_page_room;
  assign w_page_room = (32'd1 << PAGE_BYTES_LOG2)
                     - {{(32-PAGE_BYTES_LOG2){1'b0}}, r_cur_addr[PAGE_BYTES_LOG2-1:0]};
`endif

  // Burst length from the current registers: remaining, clipped by tCSM (and page)
  always_comb begin
    w_len32 = 32'(r_remaining);
    if ((r_cs_lim != 16'd0) && (32'(r_cs_lim) < w_len32)) w_len32 = 32'(r_cs_lim);
`ifdef HYPER_BURST_PAGE_SPLIT_EN
    if (w_page_room < w_len32) w_len32 = w_page_room;
`endif
    if (r_reg) w_len32 = 32'd2;
  end

  assign w_len = w_len32[TRANS_SIZE-1:0];

  assign trans_ready_o = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign burst_valid_o = (r_state == S_ISSUE);
  assign trans_done_o  = (r_state == S_DONE);
  assign burst_addr_o  = r_cur_addr;
  assign burst_len_o   = w_len;
  assign burst_rx_o    = r_rx;
  assign burst_reg_o   = r_reg;
  // Qualified by ISSUE so the flag reads 0 outside an active command (incl. reset)
  assign burst_last_o  = (r_state == S_ISSUE) && ((w_len == r_remaining) || r_reg);

  // Control FSM: accept descriptor, issue bursts, wait for PHY, signal completion
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= 32'd0;
      r_remaining <= '0;
      r_cs_lim    <= 16'd0;
      r_rx        <= 1'b0;
      r_reg       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trans_valid_i) begin
            r_cur_addr  <= w_addr;
            r_remaining <= w_size;
            r_rx        <= w_rx;
            r_reg       <= (w_mode[2:0] == 3'h1);
            // odd limits round down to even; 1 therefore becomes 0 = unlimited
            r_cs_lim    <= {cfg_cs_max_i[15:1], 1'b0};
            r_state     <= (w_size == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (burst_ready_i) begin
            r_cur_addr  <= r_cur_addr + w_len32;
            r_remaining <= r_reg ? '0 : (r_remaining - w_len);
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (phy_done_i) r_state <= (r_remaining == '0) ? S_DONE : S_ISSUE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hyper_burst_splitter.md
Name: hyper_burst_splitter

Overview:
- Sits directly downstream of the HyperBus register interface.
- Accepts one packed transaction descriptor (start address, byte size, direction, mode) over a valid/ready handshake.
- Splits the transaction into PHY bursts bounded by the chip-select max length (tCSM).
- Issues each burst to the PHY command port and waits for the PHY to finish it.
- Pulses a completion strobe once the last burst is done.

Parameters:
TRANS_SIZE, 16, width of byte-size fields
TRANS_DATA_SIZE, 32+TRANS_SIZE+4+1, width of packed descriptor
PAGE_BYTES_LOG2, 10, log2 of page size in bytes (used only with the optional feature)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
trans_data_i  in  TRANS_DATA_SIZE  descriptor: [TRANS_DATA_SIZE-1 -: 32]=start addr, [TRANS_SIZE+4:5]=size bytes, [4]=rx, [3:0]=mode
trans_valid_i  in  1  descriptor valid
trans_ready_o  out  1  descriptor accepted when high with valid
cfg_cs_max_i  in  16  max burst bytes; 0 = unlimited
burst_addr_o  out  32  burst start byte address
burst_len_o  out  TRANS_SIZE  burst length in bytes
burst_rx_o  out  1  1=read, 0=write
burst_reg_o  out  1  register-space access
burst_last_o  out  1  final burst of the transaction
burst_valid_o  out  1  burst command valid
burst_ready_i  in  1  PHY accepts burst command
phy_done_i  in  1  one-cycle pulse: PHY finished current burst
trans_done_o  out  1  one-cycle pulse: transaction complete
busy_o  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered or decoded from state plus registers.
- Reset values: state=IDLE; trans_ready_o=1, busy_o=0; all other outputs 0. Internal registers cur_addr, remaining, cs_lim, rx, reg are cleared to 0.
- IDLE:
  - trans_ready_o=1.
  - On trans_valid_i, latch cur_addr=addr, remaining=size, rx, reg=(mode[2:0]==3'h1), cs_lim={cfg_cs_max_i[15:1],1'b0}.
  - Next state: DONE if size==0, else ISSUE.
  - cfg_cs_max_i is sampled only at acceptance; later changes do not affect an in-flight transaction.
- trans_ready_o=0 in every state other than IDLE.
- Burst length is combinational from registers:
  - reg access: len = 2.
  - otherwise: len = min(remaining, cs_lim) when cs_lim!=0, else remaining.
  - Odd cfg_cs_max_i values round down to even; a cs_max of 1 rounds to 0 = unlimited.
- burst_addr_o=cur_addr; burst_len_o=len; burst_last_o=(len==remaining) || reg.
- ISSUE:
  - burst_valid_o=1. Fields are held stable while burst_ready_i=0.
  - On burst_ready_i: cur_addr+=len (32-bit wrap), remaining-=len (reg: remaining=0), go to WAIT.
- WAIT:
  - burst_valid_o=0.
  - On phy_done_i: DONE if remaining==0, else ISSUE.
  - phy_done_i in any other state is ignored.
- DONE: trans_done_o=1 for exactly one cycle, then IDLE.
- Latency:
  - Descriptor accepted in cycle N → burst_valid_o high in N+1.
  - phy_done_i in cycle M → next burst_valid_o in M+1, or trans_done_o in M+1.
  - Zero-size descriptor accepted in N → trans_done_o in N+1 with no burst issued.
- The next descriptor can be accepted in the cycle after DONE at the earliest.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight transaction is dropped with no done pulse.
- The remaining counter never underflows, since len ≤ remaining by construction.

Optional Feature:
- Macro: HYPER_BURST_PAGE_SPLIT_EN.
- Defined: for non-reg bursts, len is additionally limited to 2^PAGE_BYTES_LOG2 − cur_addr[PAGE_BYTES_LOG2-1:0]. No burst crosses a page boundary, and burst_last_o follows the same len==remaining rule.
- Undefined: no page limit; bursts are bounded only by remaining and cs_lim.

Test Plan:
- Even split: cs_max=0x0100, addr=0x1000, size=0x0300, rx=1 → three bursts (0x1000,0x100), (0x1100,0x100), (0x1200,0x100,last=1); trans_done_o pulses once, one cycle after the third phy_done_i.
- Remainder split with odd cs_max: cs_max=0x0101, addr=0x0, size=0x0150 → bursts (0x000,0x100,last=0), (0x100,0x050,last=1).
- Register access and PHY backpressure: mode=1, addr=0x800, size=0x40 → single burst len=2, burst_reg_o=1, last=1. Hold burst_ready_i=0 for 5 cycles → fields stable; WAIT entered on the ready cycle.
- Zero size: size=0, accepted in cycle N → no burst_valid_o; trans_done_o=1 in N+1.
- Page split: with HYPER_BURST_PAGE_SPLIT_EN, cs_max=0, addr=0x3F0, size=0x40 → bursts (0x3F0,0x10), (0x400,0x30). Without the macro → single burst (0x3F0,0x40).
- Reset mid-operation: assert rstn_i=0 during WAIT of burst 2 of 3 → all outputs at reset values in the same cycle, trans_ready_o=1 after release, no trans_done_o. A new descriptor then completes normally.
